// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer
// Multi-cycle execute sequencer in front of a 4-entry register file with one
// combinational read port and one synchronous write port. An instruction is
// taken in IDLE, its operands are fetched one per cycle through the single read
// port, and the ALU result is written back in a single WRITE cycle that also
// updates the zero/carry flags.
//
// Handshake: instr_ready is high only in IDLE (and never during reset); an
// instruction transfers on a rising edge where instr_valid && instr_ready.
// instr_valid seen while busy is ignored, so upstream must hold it until
// accepted. No back-to-back overlap: after WRITE the sequencer spends one IDLE
// cycle before the next transfer.

module reg_op_sequencer #(
   parameter int DATA_WIDTH  = 16,
   parameter int INDEX_WIDTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   instr_valid,
   output logic                   instr_ready,
   input  logic [2:0]             opcode,
   input  logic [INDEX_WIDTH-1:0] rd,
   input  logic [INDEX_WIDTH-1:0] rs,
   input  logic [INDEX_WIDTH-1:0] rt,
   input  logic [DATA_WIDTH-1:0]  imm,
   output logic [INDEX_WIDTH-1:0] rf_read_index,
   input  logic [DATA_WIDTH-1:0]  rf_read_data,
   output logic [INDEX_WIDTH-1:0] rf_write_index,
   output logic                   rf_write_enable,
   output logic [DATA_WIDTH-1:0]  rf_write_data,
   output logic                   done,
   output logic                   busy,
   output logic                   flag_zero,
   output logic                   flag_carry,
   output logic [1:0]             dbg_state
);

   // Opcode encoding
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_MOV = 3'd5;
   localparam logic [2:0] OP_LI  = 3'd6;
   localparam logic [2:0] OP_SHL = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_READ_A = 2'd1,
      S_READ_B = 2'd2,
      S_WRITE  = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_next_state;

   // Latched instruction and captured operands
   logic [2:0]             r_opcode;
   logic [INDEX_WIDTH-1:0] r_rd;
   logic [INDEX_WIDTH-1:0] r_rs;
   logic [INDEX_WIDTH-1:0] r_rt;
   logic [DATA_WIDTH-1:0]  r_imm;
   logic [DATA_WIDTH-1:0]  r_op_a;
   logic [DATA_WIDTH-1:0]  r_op_b;
   logic                   r_flag_zero;
   logic                   r_flag_carry;

   // ALU
   logic [DATA_WIDTH:0]    w_sum;
   logic [DATA_WIDTH-1:0]  w_result;
   logic                   w_carry;
   logic                   w_accept;

   // instr_ready is already forced low during reset, so an accept can never
   // coincide with a reset edge.
   assign w_accept = instr_valid & instr_ready;

   // State register; reset takes priority over everything else.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: LI skips both reads, MOV/SHL skip the second read.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_next_state = (opcode == OP_LI) ? S_WRITE : S_READ_A;
            end
         end
         S_READ_A: begin
            if ((r_opcode == OP_MOV) || (r_opcode == OP_SHL)) begin
               w_next_state = S_WRITE;
            end else begin
               w_next_state = S_READ_B;
            end
         end
         S_READ_B: w_next_state = S_WRITE;
         S_WRITE:  w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // Moore outputs; everything is held at zero while reset is asserted so an
   // aborted operation cannot leak a write in the reset cycle.
   always_comb begin
      instr_ready     = 1'b0;
      busy            = 1'b0;
      done            = 1'b0;
      rf_read_index   = '0;
      rf_write_index  = '0;
      rf_write_enable = 1'b0;
      rf_write_data   = '0;
      flag_zero       = 1'b0;
      flag_carry      = 1'b0;
      dbg_state       = 2'd0;
      if (!reset) begin
         flag_zero  = r_flag_zero;
         flag_carry = r_flag_carry;
         dbg_state  = r_state;
         busy       = (r_state != S_IDLE);
         case (r_state)
            S_IDLE:   instr_ready = 1'b1;
            S_READ_A: rf_read_index = r_rs;
            S_READ_B: rf_read_index = r_rt;
            S_WRITE: begin
               rf_write_enable = 1'b1;
               rf_write_index  = r_rd;
               rf_write_data   = w_result;
               done            = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Result and carry from the latched opcode and captured operands.
   always_comb begin
      w_sum    = {1'b0, r_op_a} + {1'b0, r_op_b};
      w_result = '0;
      w_carry  = 1'b0;
      case (r_opcode)
         OP_ADD: begin
            w_result = w_sum[DATA_WIDTH-1:0];
            w_carry  = w_sum[DATA_WIDTH];
         end
         OP_SUB: begin
            w_result = r_op_a - r_op_b;
            w_carry  = (r_op_a < r_op_b);
         end
         OP_AND:  w_result = r_op_a & r_op_b;
         OP_OR:   w_result = r_op_a | r_op_b;
         OP_XOR:  w_result = r_op_a ^ r_op_b;
         OP_MOV:  w_result = r_op_a;
         OP_LI:   w_result = r_imm;
         OP_SHL:  w_result = r_op_a << r_imm[3:0];
         default: w_result = '0;
      endcase
   end

   // Instruction latch, operand capture and flag update.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_opcode     <= '0;
         r_rd         <= '0;
         r_rs         <= '0;
         r_rt         <= '0;
         r_imm        <= '0;
         r_op_a       <= '0;
         r_op_b       <= '0;
         r_flag_zero  <= 1'b0;
         r_flag_carry <= 1'b0;
      end else begin
         if (w_accept) begin
            r_opcode <= opcode;
            r_rd     <= rd;
            r_rs     <= rs;
            r_rt     <= rt;
            r_imm    <= imm;
         end
         if (r_state == S_READ_A) begin
            r_op_a <= rf_read_data;
         end
         if (r_state == S_READ_B) begin
            r_op_b <= rf_read_data;
         end
         if (r_state == S_WRITE) begin
            r_flag_zero  <= (w_result == '0);
            r_flag_carry <= w_carry;
         end
      end
   end

   // Structural invariants of the handshake and writeback.
   a_done_writes : assert property (@(posedge clk) disable iff (reset)
      done |-> rf_write_enable);
   a_ready_idle : assert property (@(posedge clk) disable iff (reset)
      instr_ready |-> !busy);
   a_write_one_cycle : assert property (@(posedge clk) disable iff (reset)
      rf_write_enable |=> !rf_write_enable);

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed bench for reg_op_sequencer with a behavioural register file.
module tb_reg_op_sequencer;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_MOV = 3'd5;
   localparam logic [2:0] OP_LI  = 3'd6;
   localparam logic [2:0] OP_SHL = 3'd7;

   logic        clk;
   logic        reset;
   logic        instr_valid;
   logic        instr_ready;
   logic [2:0]  opcode;
   logic [1:0]  rd;
   logic [1:0]  rs;
   logic [1:0]  rt;
   logic [15:0] imm;
   logic [1:0]  rf_read_index;
   logic [15:0] rf_read_data;
   logic [1:0]  rf_write_index;
   logic        rf_write_enable;
   logic [15:0] rf_write_data;
   logic        done;
   logic        busy;
   logic        flag_zero;
   logic        flag_carry;
   logic [1:0]  dbg_state;

   int checks = 0;
   int failures = 0;

   // Expected writebacks as {index, data}
   logic [17:0] exp_q[$];

   // Behavioural register file: combinational read, synchronous write
   logic [15:0] rf[4];

   reg_op_sequencer #(.DATA_WIDTH(16), .INDEX_WIDTH(2)) dut (
      .clk             (clk),
      .reset           (reset),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .opcode          (opcode),
      .rd              (rd),
      .rs              (rs),
      .rt              (rt),
      .imm             (imm),
      .rf_read_index   (rf_read_index),
      .rf_read_data    (rf_read_data),
      .rf_write_index  (rf_write_index),
      .rf_write_enable (rf_write_enable),
      .rf_write_data   (rf_write_data),
      .done            (done),
      .busy            (busy),
      .flag_zero       (flag_zero),
      .flag_carry      (flag_carry),
      .dbg_state       (dbg_state)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign rf_read_data = rf[rf_read_index];

   always @(posedge clk) begin
      if (rf_write_enable) rf[rf_write_index] <= rf_write_data;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Scoreboard: every write pulse must match the next expected writeback
   always @(negedge clk) begin
      if (rf_write_enable) begin
         if (exp_q.size() == 0) begin
            check("spurious_wr", 32'(rf_write_index), 32'hDEAD);
         end else begin
            logic [17:0] e;
            e = exp_q.pop_front();
            check("wr_index", 32'(rf_write_index), 32'(e[17:16]));
            check("wr_data", 32'(rf_write_data), 32'(e[15:0]));
            check("wr_done", 32'(done), 1);
         end
      end
   end

   // Issue one instruction and check latency, read-port usage and flags
   task automatic do_op(input logic [2:0] op, input logic [1:0] rd_i, input logic [1:0] rs_i,
                        input logic [1:0] rt_i, input logic [15:0] imm_i, input int exp_lat,
                        input logic [15:0] exp_data, input logic exp_z, input logic exp_c);
      int n;
      int lat;
      exp_q.push_back({rd_i, exp_data});
      @(negedge clk);
      opcode = op; rd = rd_i; rs = rs_i; rt = rt_i; imm = imm_i;
      instr_valid = 1'b1;
      n = 0;
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ready", 32'(instr_ready), 1);
      @(posedge clk);
      #1 instr_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k;
            check("write_rd_idx", 32'(rf_read_index), 0);
            break;
         end
         check("busy", 32'(busy), 1);
         if (k == 1) check("read_a_idx", 32'(rf_read_index), 32'(rs_i));
         if (k == 2) check("read_b_idx", 32'(rf_read_index), 32'(rt_i));
      end
      check("latency", lat, exp_lat);
      @(negedge clk);
      check("flag_zero", 32'(flag_zero), 32'(exp_z));
      check("flag_carry", 32'(flag_carry), 32'(exp_c));
      check("idle_busy", 32'(busy), 0);
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ready_bits;
      logic [7:0] done_bits;
      for (int i = 0; i < 4; i++) rf[i] = 16'h0000;
      reset = 1'b1;
      instr_valid = 1'b0;
      opcode = 3'd0; rd = 2'd0; rs = 2'd0; rt = 2'd0; imm = 16'h0000;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(instr_ready), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_wen", 32'(rf_write_enable), 0);
      check("rst_done", 32'(done), 0);
      check("rst_fz", 32'(flag_zero), 0);
      check("rst_fc", 32'(flag_carry), 0);
      reset = 1'b0;
      #1;
      check("post_rst_ready", 32'(instr_ready), 1);

      // op, rd, rs, rt, imm, latency, data, zero, carry
      do_op(OP_LI,  2'd2, 2'd0, 2'd0, 16'h1234, 1, 16'h1234, 1'b0, 1'b0);
      do_op(OP_LI,  2'd0, 2'd0, 2'd0, 16'hFFFF, 1, 16'hFFFF, 1'b0, 1'b0);
      do_op(OP_LI,  2'd1, 2'd0, 2'd0, 16'h0001, 1, 16'h0001, 1'b0, 1'b0);
      do_op(OP_ADD, 2'd3, 2'd0, 2'd1, 16'h0000, 3, 16'h0000, 1'b1, 1'b1);
      do_op(OP_SUB, 2'd1, 2'd1, 2'd0, 16'h0000, 3, 16'h0002, 1'b0, 1'b1);
      do_op(OP_LI,  2'd1, 2'd0, 2'd0, 16'h0F0F, 1, 16'h0F0F, 1'b0, 1'b0);
      do_op(OP_SHL, 2'd0, 2'd1, 2'd3, 16'h0004, 2, 16'hF0F0, 1'b0, 1'b0);
      do_op(OP_MOV, 2'd2, 2'd0, 2'd3, 16'h0000, 2, 16'hF0F0, 1'b0, 1'b0);
      do_op(OP_AND, 2'd3, 2'd0, 2'd1, 16'h0000, 3, 16'h0000, 1'b1, 1'b0);
      do_op(OP_OR,  2'd3, 2'd0, 2'd1, 16'h0000, 3, 16'hFFFF, 1'b0, 1'b0);
      do_op(OP_XOR, 2'd3, 2'd3, 2'd0, 16'h0000, 3, 16'h0F0F, 1'b0, 1'b0);
      do_op(OP_SHL, 2'd2, 2'd1, 2'd0, 16'h0010, 2, 16'h0F0F, 1'b0, 1'b0);
      do_op(OP_ADD, 2'd0, 2'd0, 2'd0, 16'h0000, 3, 16'hE1E0, 1'b0, 1'b1);

      // Two ADDs with instr_valid held high throughout
      exp_q.push_back({2'd2, 16'hF0EF});
      exp_q.push_back({2'd3, 16'h1E1E});
      ready_bits = 8'h00;
      done_bits = 8'h00;
      @(negedge clk);
      opcode = OP_ADD; rd = 2'd2; rs = 2'd0; rt = 2'd1; imm = 16'h0000;
      instr_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         if (i == 1) begin
            rd = 2'd3; rs = 2'd3; rt = 2'd3;
         end
         ready_bits[i] = instr_ready;
         done_bits[i] = done;
      end
      instr_valid = 1'b0;
      check("hold_ready_pattern", 32'(ready_bits), 32'h11);
      check("hold_done_pattern", 32'(done_bits), 32'h88);
      @(negedge clk);
      check("hold_fz", 32'(flag_zero), 0);
      check("hold_fc", 32'(flag_carry), 0);

      do_op(OP_SUB, 2'd1, 2'd1, 2'd0, 16'h0000, 3, 16'h2D2F, 1'b0, 1'b1);

      // Reset in READ_B of an ADD: no write, flags cleared
      @(negedge clk);
      opcode = OP_ADD; rd = 2'd0; rs = 2'd1; rt = 2'd2; imm = 16'h0000;
      instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      @(negedge clk);
      check("abort_state_a", 32'(dbg_state), 1);
      @(negedge clk);
      check("abort_state_b", 32'(dbg_state), 2);
      check("abort_read_b_idx", 32'(rf_read_index), 2);
      reset = 1'b1;
      #1;
      check("abort_rst_wen", 32'(rf_write_enable), 0);
      check("abort_rst_ready", 32'(instr_ready), 0);
      check("abort_rst_busy", 32'(busy), 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort_ready", 32'(instr_ready), 1);
      check("abort_busy", 32'(busy), 0);
      check("abort_fz", 32'(flag_zero), 0);
      check("abort_fc", 32'(flag_carry), 0);
      check("abort_wen", 32'(rf_write_enable), 0);
      repeat (4) @(negedge clk);
      check("abort_r0_kept", 32'(rf[0]), 32'hE1E0);

      do_op(OP_LI,  2'd3, 2'd0, 2'd0, 16'h0000, 1, 16'h0000, 1'b1, 1'b0);

      repeat (2) @(negedge clk);
      check("final_r0", 32'(rf[0]), 32'hE1E0);
      check("final_r1", 32'(rf[1]), 32'h2D2F);
      check("final_r2", 32'(rf[2]), 32'hF0EF);
      check("final_r3", 32'(rf[3]), 32'h0000);
      check("exp_q_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
